// File: rtl/ssd_scan_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan display.
// All segment encodings are active-low and ordered {a,b,c,d,e,f,g,dp}.
package ssd_scan_pkg;

    localparam int BCD_BIT_WIDTH = 4;
    localparam int SSD_BIT_WIDTH = 8;

    localparam logic [SSD_BIT_WIDTH-1:0] SSD_BLANK = 8'hFF;
    localparam logic [SSD_BIT_WIDTH-1:0] SSD_DASH  = 8'hFD;

    localparam logic [BCD_BIT_WIDTH-1:0] DISP_A     = 4'd10;
    localparam logic [BCD_BIT_WIDTH-1:0] DISP_P     = 4'd11;
    localparam logic [BCD_BIT_WIDTH-1:0] DISP_BLANK = 4'd15;

    // Active-low one-hot digit enable for scan slot idx.
    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/ssd_scan_bcd2ssd.sv
// Combinational display-code to active-low segment decoder (a..g, no dp).
// Codes 0-9 are digits, 10/11 are 'A'/'P', 12-14 a dash, 15 blank.
module bcd2ssd
    import ssd_scan_pkg::*;
(
    input  logic [BCD_BIT_WIDTH-1:0] code,
    output logic [6:0]               seg
);

    always_comb begin
        seg = SSD_BLANK[7:1];
        case (code)
            4'd0:       seg = 7'b0000001;
            4'd1:       seg = 7'b1001111;
            4'd2:       seg = 7'b0010010;
            4'd3:       seg = 7'b0000110;
            4'd4:       seg = 7'b1001100;
            4'd5:       seg = 7'b0100100;
            4'd6:       seg = 7'b0100000;
            4'd7:       seg = 7'b0001111;
            4'd8:       seg = 7'b0000000;
            4'd9:       seg = 7'b0000100;
            DISP_A:     seg = 7'b0001000;
            DISP_P:     seg = 7'b0011000;
            4'd12,
            4'd13,
            4'd14:      seg = SSD_DASH[7:1];
            DISP_BLANK: seg = SSD_BLANK[7:1];
            default:    seg = SSD_BLANK[7:1];
        endcase
    end

endmodule

// File: rtl/ssd_scan.sv
// Time-multiplexed driver for a four-digit common-anode 7-segment display,
// with per-digit decimal point and per-digit blink.
module ssd_scan
    import ssd_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 500
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BCD_BIT_WIDTH-1:0] dig0,
    input  logic [BCD_BIT_WIDTH-1:0] dig1,
    input  logic [BCD_BIT_WIDTH-1:0] dig2,
    input  logic [BCD_BIT_WIDTH-1:0] dig3,
    input  logic [3:0]               dp_mask,
    input  logic [3:0]               blink_mask,
    output logic [3:0]               ssd_ctl,
    output logic [SSD_BIT_WIDTH-1:0] ssd
);

    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic [DIV_W-1:0]         div_q, div_d;
    logic [1:0]               idx_q, idx_d, idx_nxt;
    logic [BLINK_W-1:0]       blink_cnt_q, blink_cnt_d;
    logic                     blink_phase_q, blink_phase_d;
    logic [3:0]               ctl_q, ctl_d;
    logic [SSD_BIT_WIDTH-1:0] ssd_q, ssd_d;
    logic                     scan_tick;
    logic [BCD_BIT_WIDTH-1:0] digits [4];
    logic [BCD_BIT_WIDTH-1:0] code_sel;
    logic [6:0]               seg;

    assign digits[0] = dig0;
    assign digits[1] = dig1;
    assign digits[2] = dig2;
    assign digits[3] = dig3;

    // The slot being loaded is the one after the current index.
    assign idx_nxt  = idx_q + 2'd1;
    assign code_sel = digits[idx_nxt];

    bcd2ssd u_bcd2ssd (
        .code (code_sel),
        .seg  (seg)
    );

    always_comb begin
        scan_tick     = (div_q == DIV_LAST);
        div_d         = scan_tick ? '0 : div_q + DIV_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        ctl_d         = ctl_q;
        ssd_d         = ssd_q;
        if (scan_tick) begin
            idx_d = idx_nxt;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
            // The new blink phase applies to the slot loaded on the wrap tick.
            ctl_d = digit_enable(idx_nxt);
            if (blink_phase_d && blink_mask[idx_nxt]) begin
                ssd_d = SSD_BLANK;
            end else begin
                ssd_d = {seg, ~dp_mask[idx_nxt]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            idx_q         <= 2'd3;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            ctl_q         <= 4'b1111;
            ssd_q         <= SSD_BLANK;
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            ctl_q         <= ctl_d;
            ssd_q         <= ssd_d;
        end
    end

    assign ssd_ctl = ctl_q;
    assign ssd     = ssd_q;

endmodule

// File: doc/ssd_scan.md
Name: ssd_scan

Overview:
- Consumer end of the four-digit BCD display bus (dig3..dig0) produced by the time/AM-PM selection logic.
- Time-multiplexes the four digit codes onto one common-anode 7-segment display: one digit enable active at a time, with matching segment pattern.
- Decodes BCD 0-9 plus display codes 10 ('A'), 11 ('P'), 12-14 ('-') and 15 (blank).
- Supports per-digit blink (time-set mode) and per-digit decimal point.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
BLINK_TICKS, 500, scan ticks per blink half-period (0.5 s at default SCAN_DIV); legal range >= 1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
dig0  input  BCD_BIT_WIDTH(4)  rightmost digit code.
dig1  input  4  digit 1 code.
dig2  input  4  digit 2 code.
dig3  input  4  leftmost digit code.
dp_mask  input  4  bit i=1 lights the decimal point on digit i.
blink_mask  input  4  bit i=1 blanks digit i during the blink off-phase.
ssd_ctl  output  4  digit enables, active-low; bit i drives digit i.
ssd  output  8  segments, active-low, ordered {a,b,c,d,e,f,g,dp} MSB..LSB.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). All state clears immediately on rst_n=0, independent of clk.
- Reset values:
  - ssd_ctl=4'b1111, ssd=8'hFF (display dark).
  - div counter=0, scan index=3, blink counter=0, blink_phase=0 (on-phase).
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick is a 1-cycle pulse in the cycle the counter equals SCAN_DIV-1.
  - First tick occurs SCAN_DIV cycles after reset release.
- Scan on each tick:
  - idx <= idx+1 modulo 4 (2-bit wrap 3->0), so the first slot after reset is digit 0. Order 0,1,2,3,0...
  - The selected digit code, its dp_mask bit and its blink_mask bit are sampled at the tick edge.
  - ssd_ctl and ssd change together on the clock edge that ends the tick cycle; latency is 1 clk from tick, with no skew between ctl and segments.
- Outputs are held for the whole slot:
  - Input changes mid-slot are not visible until that digit's next slot.
  - Outputs come only from registers, with no combinational path from inputs.
- ssd_ctl in slot i: only bit i is low (e.g. digit 2 -> 4'b1011).
- Segment decode (dp bit=1), giving ssd[7:1] then the full byte with dp off:
  - 0 -> 0000001 (8'h03); 1 -> 1001111 (9F); 2 -> 0010010 (25); 3 -> 0000110 (0D); 4 -> 1001100 (99).
  - 5 -> 0100100 (49); 6 -> 0100000 (41); 7 -> 0001111 (1F); 8 -> 0000000 (01); 9 -> 0000100 (09).
  - 10 'A' -> 0001000 (11); 11 'P' -> 0011000 (31); 12-14 '-' -> 1111110 (FD); 15 blank -> 1111111 (FF).
- Decimal point: ssd[0]=0 if the sampled dp_mask bit=1.
- Blink:
  - The blink counter counts scan ticks 0..BLINK_TICKS-1; at wrap, blink_phase toggles.
  - If blink_phase=1 and the sampled blink_mask bit=1, ssd=8'hFF for that slot, including dp. ssd_ctl still scans normally, so scan timing is unchanged.
- Simultaneous events: a tick coinciding with blink wrap uses the new blink_phase for the slot being loaded.
- Reset mid-slot: outputs go dark immediately; the scan restarts at digit 0 after SCAN_DIV cycles.

Decomposition:
- global.v (shared include):
  - BCD_BIT_WIDTH, ENABLED/DISABLED and BCD_* constants already defined there.
  - Add SSD_BIT_WIDTH=8, SSD_BLANK=8'hFF, SSD_DASH=8'hFD, DISP_A=4'd10, DISP_P=4'd11, DISP_BLANK=4'd15.
- Sub-module bcd2ssd: purely combinational, 4-bit code -> 7-bit active-low segments per the table above.
- ssd_scan instantiates bcd2ssd once on the muxed digit and registers the result.

Test Plan:
1. Reset: hold rst_n=0, then release -> ssd_ctl=1111, ssd=FF until the first tick. With SCAN_DIV=4, the first change is at cycle 5 after release: ctl=1110.
2. Rotation: SCAN_DIV=4, dig3..0=8,3,1,0, masks=0 -> ctl/ssd sequence 1110/03, 1101/9F, 1011/0D, 0111/01, then repeats; each slot lasts 4 cycles.
3. Special codes: dig0=10, dig1=11, dig2=12, dig3=15 -> 11, 31, FD, FF. Set dp_mask=0010 -> digit 1 gives 30.
4. Blink: SCAN_DIV=2, BLINK_TICKS=4, dig=5555, blink_mask=0001:
   - Digit 0 shows 49 for ticks 0-3, FF for ticks 4-7, 49 again from tick 8.
   - Other digits show 49 throughout.
5. Mid-slot change: change dig0 from 1 to 7 during slot 0 -> ssd stays 9F until slot 0's next visit, then 1F.
6. Async reset mid-slot: assert rst_n between clock edges during slot 2 -> ctl=1111 and ssd=FF without waiting for a clk edge. After release, the scan resumes at digit 0.
